// File: rtl/demux4_stream_sched.sv
// Steers a single valid/ready word stream onto four one-entry channel registers,
// either by address (S) or by a strict round-robin pointer.
module demux4_stream_sched #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  I,
  input  logic          I_valid,
  output logic          I_ready,
  input  logic [1:0]    S,
  input  logic          MODE,
  output logic [W-1:0]  A,
  output logic [W-1:0]  B,
  output logic [W-1:0]  C,
  output logic [W-1:0]  D,
  output logic [3:0]    V,
  input  logic [3:0]    R,
  output logic [1:0]    PTR,
  output logic [CW-1:0] CNT
);

  logic [W-1:0]  ch_data [4];
  logic [3:0]    ch_valid;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [1:0]    tgt;
  logic          accept;
  logic [3:0]    load;

  always_comb begin
    tgt     = MODE ? ptr : S;
    I_ready = ~ch_valid[tgt] | R[tgt];
    accept  = I_valid & I_ready;
    load    = accept ? (4'b0001 << tgt) : '0;
  end

  // A refill takes priority over the drain of the same channel, so a full
  // channel with its consumer ready sustains one word per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 4; k++) ch_data[k] <= '0;
      ch_valid <= '0;
      ptr      <= '0;
      cnt      <= '0;
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (load[k]) begin
          ch_data[k]  <= I;
          ch_valid[k] <= 1'b1;
        end else if (ch_valid[k] && R[k]) begin
          ch_data[k]  <= '0;
          ch_valid[k] <= 1'b0;
        end
      end
      if (accept) begin
        cnt <= cnt + 1'b1;
        if (MODE) ptr <= ptr + 2'd1;
      end
    end
  end

  assign A   = ch_data[0];
  assign B   = ch_data[1];
  assign C   = ch_data[2];
  assign D   = ch_data[3];
  assign V   = ch_valid;
  assign PTR = ptr;
  assign CNT = cnt;

endmodule
